// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory port between I-cache (port 0) and D-cache (port 1), round-robin with a watchdog.
// Latency : one cycle of arbitration (request sampled in IDLE, driven to memory next cycle); return path is combinational.
// Backpressure: requesters hold Req until their Rdy pulse; a dropped Req aborts the grant. Build option: ARB_WB_LOCK_EN.
module mem_port_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int BLK_W   = 128,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Wr0,
  input  logic              Wr1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [BLK_W-1:0]  WData0,
  input  logic [BLK_W-1:0]  WData1,
  output logic              Rdy0,
  output logic              Rdy1,
  output logic              Req_Low,
  output logic              Wr_Low,
  output logic [ADDR_W-1:0] A_Low,
  output logic [BLK_W-1:0]  WData_Low,
  input  logic              Rdy_Low,
  output logic [1:0]        Gnt,
  output logic              Err_Timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  // A zero TIMEOUT turns the watchdog off; TO_LAST is then never compared.
  localparam bit              TO_EN   = (TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            rr_last_q, rr_last_d;  // index of the port served last
  logic [TO_W-1:0] cnt_q, cnt_d;          // cycles spent in the current grant

  logic gnt_port;
  logic to_hit;

  assign gnt_port = (state_q == G1);

  // Watchdog fires on the last allowed grant cycle; a same-cycle Rdy_Low takes precedence.
  assign to_hit = TO_EN && (state_q != IDLE) && (cnt_q == TO_LAST) && !Rdy_Low;
  assign Err_Timeout = to_hit;
  assign Gnt = {state_q == G1, state_q == G0};

  // Downstream mux and return routing, purely from the registered grant.
  always_comb begin
    Req_Low   = 1'b0;
    Wr_Low    = 1'b0;
    A_Low     = '0;
    WData_Low = '0;
    Rdy0      = 1'b0;
    Rdy1      = 1'b0;
    if (state_q == G0) begin
      Req_Low   = Req0;
      Wr_Low    = Wr0;
      A_Low     = Addr0;
      WData_Low = WData0;
      Rdy0      = Rdy_Low;
    end else if (state_q == G1) begin
      Req_Low   = Req1;
      Wr_Low    = Wr1;
      A_Low     = Addr1;
      WData_Low = WData1;
      Rdy1      = Rdy_Low;
    end
  end

  // Next-state: arbitration in IDLE; completion, watchdog, abort and counting in a grant.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (Req0 && Req1) begin
          state_d = rr_last_q ? G0 : G1;
        end else if (Req0) begin
          state_d = G0;
        end else if (Req1) begin
          state_d = G1;
        end
      end
      G0, G1: begin
        if (Rdy_Low) begin
          rr_last_d = gnt_port;
          cnt_d     = '0;
`ifdef ARB_WB_LOCK_EN
          // Keep the grant after a write-back so the refill follows back-to-back.
          if (!Wr_Low) begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else if (to_hit) begin
          // Charge the stalled port so the other one wins the next tie.
          state_d   = IDLE;
          rr_last_d = gnt_port;
          cnt_d     = '0;
        end else if (!Req_Low) begin
          // Requester withdrew: abandon without touching fairness.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset makes port 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
